// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for the single external memory port.
// Optional starvation guard for fetch enabled by defining ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              data_ready_mem,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StResp = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;  // 1: data access, 0: fetch
    logic              drop_q, drop_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic force_if;
    logic grant_dm;
    logic grant_if;
    logic if_waiting;

    assign if_waiting = if_req && !if_flush;

`ifdef ARB_FAIR_EN
    logic [3:0] starve_q, starve_d;

    assign force_if = (starve_q == StarveLim) && if_waiting;

    always_comb begin
        starve_d = starve_q;
        if (state_q == StIdle) begin
            if (grant_if) begin
                starve_d = '0;
            end else if (grant_dm && if_waiting) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_starve;
    assign unused_starve = ^StarveLim;
    assign force_if      = 1'b0;
`endif

    assign grant_dm = dm_req && !force_if;
    assign grant_if = if_waiting && !grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (grant_dm || grant_if) begin
                    state_d     = StReq;
                    owner_d     = grant_dm;
                    drop_d      = 1'b0;
                    mem_valid_d = 1'b1;
                    mem_we_d    = grant_dm && dm_we;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                end
            end
            StReq: begin
                if (!owner_q && if_flush) drop_d = 1'b1;
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (!owner_q && if_flush) drop_d = 1'b1;
                if (mem_rvalid) begin
                    state_d = StDone;
                    if (owner_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_done_d  = 1'b1;
                    end else if (!(drop_q || if_flush)) begin
                        // A flush in the response cycle itself still discards the fetch.
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                drop_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            drop_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

    // Stall is combinational so the pipeline freezes in the same cycle dm_req rises.
    assign data_ready_mem = !rstn || !dm_req || dm_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; fairness steps run only when ARB_FAIR_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, if_flush, if_done;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_done;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        data_ready_mem;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_flush       (if_flush),
        .if_done        (if_done),
        .if_rdata       (if_rdata),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_wdata       (dm_wdata),
        .dm_done        (dm_done),
        .dm_rdata       (dm_rdata),
        .data_ready_mem (data_ready_mem),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef ARB_FAIR_EN
    logic [31:0] grant_addr [6];
    int          n_grant;
`endif

    initial begin
        rstn = 1'b0; if_req = 0; if_flush = 0; if_addr = 0;
        dm_req = 1; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        tick(); tick();
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_dm_done", 32'(dm_done), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        chk("rst_drm_forced", 32'(data_ready_mem), 32'd1);
        dm_req = 0;
        #2 rstn = 1'b1;
        tick();

        // Single load: N..N+3
        dm_req = 1; dm_addr = 32'h100; mem_ready = 1; #1;
        chk("ld_drm_n", 32'(data_ready_mem), 32'd0);
        tick();
        chk("ld_valid_n1", 32'(mem_valid), 32'd1);
        chk("ld_addr_n1", mem_addr, 32'h100);
        chk("ld_we_n1", 32'(mem_we), 32'd0);
        chk("ld_drm_n1", 32'(data_ready_mem), 32'd0);
        tick();
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; #1;
        chk("ld_valid_n2", 32'(mem_valid), 32'd0);
        chk("ld_drm_n2", 32'(data_ready_mem), 32'd0);
        tick();
        chk("ld_done_n3", 32'(dm_done), 32'd1);
        chk("ld_rdata_n3", dm_rdata, 32'hDEADBEEF);
        chk("ld_drm_n3", 32'(data_ready_mem), 32'd1);
        dm_req = 0; mem_rvalid = 0;
        tick();
        chk("ld_done_n4", 32'(dm_done), 32'd0);

        // Contention: data wins, fetch granted in the IDLE after dm_done
        dm_req = 1; dm_addr = 32'h300; if_req = 1; if_addr = 32'h10;
        tick();
        chk("ct_addr_n1", mem_addr, 32'h300);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h11112222;
        tick();
        chk("ct_dm_done", 32'(dm_done), 32'd1);
        chk("ct_if_done_n3", 32'(if_done), 32'd0);
        dm_req = 0; mem_rvalid = 0;
        tick();
        chk("ct_idle_valid", 32'(mem_valid), 32'd0);
        tick();
        chk("ct_if_valid", 32'(mem_valid), 32'd1);
        chk("ct_if_addr", mem_addr, 32'h10);
        // rvalid together with ready in REQ must be ignored
        mem_rvalid = 1; mem_rdata = 32'hDEAD0000;
        tick();
        mem_rvalid = 0;
        tick();
        chk("ct_rvalid_in_req_ignored", 32'(if_done), 32'd0);
        mem_rvalid = 1; mem_rdata = 32'hAAAA5555;
        tick();
        chk("ct_if_done", 32'(if_done), 32'd1);
        chk("ct_if_rdata", if_rdata, 32'hAAAA5555);
        if_req = 0; mem_rvalid = 0;
        tick();

        // Flush in flight
        if_req = 1; if_addr = 32'h40;
        tick();
        chk("fl_addr", mem_addr, 32'h40);
        tick();
        if_flush = 1;
        tick();
        if_flush = 0; if_addr = 32'h80; mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        tick();
        chk("fl_no_done", 32'(if_done), 32'd0);
        chk("fl_rdata_kept", if_rdata, 32'hAAAA5555);
        mem_rvalid = 0;
        tick();
        chk("fl_idle_valid", 32'(mem_valid), 32'd0);
        tick();
        chk("fl_new_valid", 32'(mem_valid), 32'd1);
        chk("fl_new_addr", mem_addr, 32'h80);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h0000CAFE;
        tick();
        chk("fl_new_done", 32'(if_done), 32'd1);
        chk("fl_new_rdata", if_rdata, 32'h0000CAFE);
        if_req = 0; mem_rvalid = 0;
        tick();

        // Flush in IDLE blocks the fetch grant for that cycle
        if_req = 1; if_addr = 32'h90; if_flush = 1;
        tick();
        chk("fi_blocked", 32'(mem_valid), 32'd0);
        if_flush = 0;
        tick();
        chk("fi_granted", 32'(mem_valid), 32'd1);
        tick();
        mem_rvalid = 1; mem_rdata = 32'h77;
        tick();
        chk("fi_done", 32'(if_done), 32'd1);
        if_req = 0; mem_rvalid = 0;
        tick();

        // Backpressure on a store
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'h12345678; mem_ready = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            chk("bp_valid", 32'(mem_valid), 32'd1);
            chk("bp_addr", mem_addr, 32'h200);
            chk("bp_wdata", mem_wdata, 32'h12345678);
            chk("bp_we", 32'(mem_we), 32'd1);
            tick();
        end
        chk("bp_valid_drop", 32'(mem_valid), 32'd0);
        chk("bp_not_done", 32'(dm_done), 32'd0);
        mem_rvalid = 1;
        tick();
        chk("bp_done_n6", 32'(dm_done), 32'd1);
        dm_req = 0; dm_we = 0; mem_rvalid = 0;
        tick();

        // Reset during RESP
        dm_req = 1; dm_addr = 32'h500;
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        chk("mr_valid", 32'(mem_valid), 32'd0);
        chk("mr_addr", mem_addr, 32'd0);
        chk("mr_wdata", mem_wdata, 32'd0);
        chk("mr_we", 32'(mem_we), 32'd0);
        chk("mr_if_rdata", if_rdata, 32'd0);
        chk("mr_dm_rdata", dm_rdata, 32'd0);
        chk("mr_drm", 32'(data_ready_mem), 32'd1);
        dm_req = 0;
        #1 rstn = 1'b1;
        tick();
        mem_rvalid = 1; mem_rdata = 32'h99999999;
        tick();
        mem_rvalid = 0;
        tick();
        chk("mr_ign_dm_done", 32'(dm_done), 32'd0);
        chk("mr_ign_if_done", 32'(if_done), 32'd0);
        chk("mr_ign_rdata", dm_rdata, 32'd0);
        chk("mr_ign_valid", 32'(mem_valid), 32'd0);

`ifdef ARB_FAIR_EN
        // Fairness: both requesters held high, expect D D D D I D
        n_grant = 0;
        dm_req = 1; dm_addr = 32'hD00; if_req = 1; if_addr = 32'h1A0;
        mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h5;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mem_valid && n_grant < 6) begin
                grant_addr[n_grant] = mem_addr;
                n_grant++;
            end
        end
        dm_req = 0; if_req = 0; mem_rvalid = 0;
        chk("fair_count", 32'(n_grant), 32'd6);
        for (int g = 0; g < 6; g++) begin
            chk("fair_order", grant_addr[g], (g == 4) ? 32'h1A0 : 32'hD00);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
